// File: rtl/mc_core_param.sv
// Parametrised multicycle RISC core: 16-bit instructions, DW-bit datapath, one shared
// instruction/data memory port with a req/ready handshake that tolerates wait states.
module mc_core_param #(
    parameter int              DW       = 16,
    parameter logic [DW-1:0]   RESET_PC = '0,
    parameter bit              ZERO_R0  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [DW-1:0] pc_out,
    output logic          retire,
    output logic          halted
);

    // Handshake: request fields stay frozen from the first mem_req cycle up to and
    // including the edge where mem_ready=1; mem_ready is ignored while mem_req=0.
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_LI  = 4'h7;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hA;
    localparam logic [3:0] OP_BNE = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;

    state_t        state, next_state;
    logic [DW-1:0] pc, a_q, b_q, d_q, alu_out, mdr, alu_res;
    logic [15:0]   ir;
    logic [DW-1:0] regs [16];
    logic [3:0]    op, rd, rs, rt;
    logic [DW-1:0] imm8_s, imm4_z, imm4_s, imm12_s, rd_val, rs_val, rt_val;
    logic          branch_taken;

    assign op      = ir[15:12];
    assign rd      = ir[11:8];
    assign rs      = ir[7:4];
    assign rt      = ir[3:0];
    assign imm8_s  = {{(DW-8){ir[7]}}, ir[7:0]};
    assign imm4_z  = {{(DW-4){1'b0}}, ir[3:0]};
    assign imm4_s  = {{(DW-4){ir[3]}}, ir[3:0]};
    assign imm12_s = {{(DW-12){ir[11]}}, ir[11:0]};

    assign rd_val = (ZERO_R0 && rd == 4'd0) ? '0 : regs[rd];
    assign rs_val = (ZERO_R0 && rs == 4'd0) ? '0 : regs[rs];
    assign rt_val = (ZERO_R0 && rt == 4'd0) ? '0 : regs[rt];

    // a_q=R[rs], b_q=R[rt], d_q=R[rd]; d_q doubles as ADDI source, branch operand and SW data
    assign branch_taken = (op == OP_BEQ && d_q == a_q) || (op == OP_BNE && d_q != a_q);

    always_comb begin
        alu_res = '0;
        case (op)
            4'h0:         alu_res = a_q + b_q;
            4'h1:         alu_res = a_q - b_q;
            4'h2:         alu_res = a_q & b_q;
            4'h3:         alu_res = a_q | b_q;
            4'h4:         alu_res = a_q ^ b_q;
            4'h5:         alu_res = {{(DW-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            4'h6:         alu_res = d_q + imm8_s;
            OP_LI:        alu_res = imm8_s;
            OP_LW, OP_SW: alu_res = a_q + imm4_z;
            default:      alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                if (op <= OP_LI)                     next_state = S_WB;
                else if (op == OP_LW || op == OP_SW) next_state = S_MEM;
                else if (op >= 4'hE)                 next_state = S_HALT;
                else                                 next_state = S_FETCH;
            end
            S_MEM:    if (mem_ready) next_state = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
    end

    // Outputs are forced quiet while rst is high, so a reset mid-transaction drops mem_req at once
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        halted    = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc;
                end
                S_EXEC:  retire = (op >= OP_BEQ);
                S_MEM: begin
                    mem_req  = 1'b1;
                    mem_addr = alu_out;
                    if (op == OP_SW) begin
                        mem_we    = 1'b1;
                        mem_wdata = d_q;
                        retire    = mem_ready;
                    end
                end
                S_WB:    retire = 1'b1;
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata[15:0];
                    pc <= pc + 1'b1;
                end
                S_DECODE: begin
                    a_q <= rs_val;
                    b_q <= rt_val;
                    d_q <= rd_val;
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (branch_taken)       pc <= pc + imm4_s;
                    else if (op == OP_JMP)  pc <= pc + imm12_s;
                end
                S_MEM: if (mem_ready && op == OP_LW) mdr <= mem_rdata;
                S_WB: if (!(ZERO_R0 && rd == 4'd0))
                    regs[rd] <= (op == OP_LW) ? mdr : alu_out;
                default: ;
            endcase
        end
    end

    assign pc_out = pc;

endmodule

// File: tb/tb_mc_core_param.sv
// Directed bench for mc_core_param: a DW=16 core on a wait-state memory model and a
// DW=32 core with RESET_PC at the top of the address space.
module tb_mc_core_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst32 = 1'b1;
    always #5 clk = ~clk;

    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic        mem_req32, mem_we32, mem_ready32, retire32, halted32;
    logic [31:0] mem_addr32, mem_wdata32, mem_rdata32, pc_out32;

    mc_core_param dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_out(pc_out), .retire(retire), .halted(halted)
    );

    mc_core_param #(.DW(32), .RESET_PC(32'hFFFF_FFFF), .ZERO_R0(1'b1)) dut32 (
        .clk(clk), .rst(rst32), .mem_req(mem_req32), .mem_we(mem_we32), .mem_addr(mem_addr32),
        .mem_wdata(mem_wdata32), .mem_rdata(mem_rdata32), .mem_ready(mem_ready32),
        .pc_out(pc_out32), .retire(retire32), .halted(halted32)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // 16-bit memory: addresses >= 0x40 use data_wait, the rest fetch_wait
    logic [15:0] img [0:255];
    logic [15:0] mem [0:255];
    int          fetch_wait = 0;
    int          data_wait = 0;
    int          wcnt, cur_wait, wr_count;
    logic [15:0] last_waddr, last_wdata;
    logic [15:0] rd_q[$];
    logic [15:0] exp_q[$];

    always_comb begin
        cur_wait  = (mem_addr >= 16'h0040) ? data_wait : fetch_wait;
        mem_ready = mem_req && (wcnt >= cur_wait);
        mem_rdata = mem[mem_addr[7:0]];
    end

    always @(posedge clk) begin
        if (rst) begin
            mem      <= img;
            wcnt     <= 0;
            wr_count <= 0;
            rd_q.delete();
        end else if (mem_req && mem_ready) begin
            wcnt <= 0;
            if (mem_we) begin
                mem[mem_addr[7:0]] <= mem_wdata;
                wr_count   <= wr_count + 1;
                last_waddr <= mem_addr;
                last_wdata <= mem_wdata;
            end else begin
                rd_q.push_back(mem_addr);
            end
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    // 32-bit memory: always zero-wait
    logic [31:0] img32 [0:255];
    logic [31:0] mem32 [0:255];
    logic [31:0] rd32_q[$];

    assign mem_ready32 = mem_req32;
    assign mem_rdata32 = mem32[mem_addr32[7:0]];

    always @(posedge clk) begin
        if (rst32) begin
            mem32 <= img32;
            rd32_q.delete();
        end else if (mem_req32 && mem_we32) begin
            mem32[mem_addr32[7:0]] <= mem_wdata32;
        end else if (mem_req32) begin
            rd32_q.push_back(mem_addr32);
        end
    end

    // Per-cycle log; cycle 1 is the first cycle after reset release
    logic        ret_log  [0:199];
    logic        req_log  [0:199];
    logic        we_log   [0:199];
    logic        halt_log [0:199];
    logic [15:0] addr_log [0:199];

    task automatic load_default();
        for (int i = 0; i < 256; i++) img[i] = 16'hE000;
    endtask

    task automatic start_prog(input int fw, input int dw);
        fetch_wait = fw;
        data_wait  = dw;
        for (int c = 0; c < 200; c++) begin
            ret_log[c] = 1'b0; req_log[c] = 1'b0; we_log[c] = 1'b0;
            halt_log[c] = 1'b0; addr_log[c] = '0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            ret_log[c]  = retire;
            req_log[c]  = mem_req;
            we_log[c]   = mem_we;
            halt_log[c] = halted;
            addr_log[c] = mem_addr;
        end
    endtask

    function automatic int first_halt();
        for (int c = 1; c < 200; c++) if (halt_log[c]) return c;
        return 0;
    endfunction

    function automatic int count_ret(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (ret_log[c]) n++;
        return n;
    endfunction

    function automatic int count_we(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (we_log[c]) n++;
        return n;
    endfunction

    function automatic int count_req(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (req_log[c]) n++;
        return n;
    endfunction

    function automatic logic [63:0] ret_bits(input int n);
        logic [63:0] v = '0;
        for (int c = 1; c <= n; c++) v[c-1] = ret_log[c];
        return v;
    endfunction

    function automatic logic [63:0] we_bits(input int n);
        logic [63:0] v = '0;
        for (int c = 1; c <= n; c++) v[c-1] = we_log[c];
        return v;
    endfunction

    logic [15:0] t1_exp [8];
    int          n_lw_req;

    initial begin
        for (int i = 0; i < 256; i++) img32[i] = '0;
        load_default();

        // reset state
        #2;
        check("rst_req", {63'b0, mem_req}, 64'd0);
        check("rst_pc", pc_out, 64'd0);
        check("rst_retire_halted", {62'b0, retire, halted}, 64'd0);

        // ALU ops, stores, r0 write suppression, zero-wait timing
        load_default();
        for (int i = 8'h30; i < 8'h40; i++) img[i] = 16'hDEAD;
        img[0]  = 16'h7105;  img[1]  = 16'h72FD;  img[2]  = 16'h0312;  img[3]  = 16'h1412;
        img[4]  = 16'h5721;  img[5]  = 16'h5812;  img[6]  = 16'h7630;  img[7]  = 16'h9360;
        img[8]  = 16'h9461;  img[9]  = 16'h9762;  img[10] = 16'h9863;  img[11] = 16'h2912;
        img[12] = 16'h3A12;  img[13] = 16'h4B12;  img[14] = 16'h6B10;  img[15] = 16'h9964;
        img[16] = 16'h9A65;  img[17] = 16'h9B66;  img[18] = 16'h0011;  img[19] = 16'h9067;
        img[20] = 16'hE000;
        t1_exp = '{16'h0002, 16'h0008, 16'h0001, 16'h0000, 16'h0005, 16'hFFFD, 16'h0008, 16'h0000};
        start_prog(0, 0);
        run_cycles(90);
        check("t1_retire_4_8_12", ret_bits(12), 64'h888);
        check("t1_halt_cycle", first_halt(), 64'd84);
        check("t1_retire_count", count_ret(1, 90), 64'd21);
        check("t1_we_cycles", count_we(1, 90), 64'd8);
        check("t1_pc_after_halt", pc_out, 64'd21);
        for (int i = 0; i < 8; i++)
            check($sformatf("t1_mem_%0h", 8'h30 + i), mem[8'h30 + i], t1_exp[i]);

        // LW with three wait states, then SW to a slow address
        load_default();
        img[0] = 16'h7640;  img[1] = 16'h8460;  img[2] = 16'h9468;  img[3] = 16'hE000;
        img[8'h40] = 16'h1234;
        img[8'h48] = 16'h0000;
        start_prog(0, 3);
        run_cycles(30);
        check("t2_retire_mask", ret_bits(22), (64'd1 << 3) | (64'd1 << 11) | (64'd1 << 18) | (64'd1 << 21));
        n_lw_req = 0;
        for (int c = 5; c <= 12; c++) if (req_log[c] && addr_log[c] == 16'h0040) n_lw_req++;
        check("t2_lw_req_stable", n_lw_req, 64'd4);
        check("t2_req_drop", {63'b0, req_log[12]}, 64'd0);
        check("t2_sw_we_cycles", count_we(1, 30), 64'd4);
        check("t2_halt_cycle", first_halt(), 64'd23);
        check("t2_mem_48", mem[8'h48], 64'h1234);

        // SW r5=0x1234 to [r6+2] with r6=0x10
        load_default();
        img[0] = 16'h7610;  img[1] = 16'h8560;  img[2] = 16'h9562;  img[3] = 16'hE000;
        img[8'h10] = 16'h1234;
        img[8'h12] = 16'h0000;
        start_prog(0, 0);
        run_cycles(20);
        check("t3_write_count", wr_count, 64'd1);
        check("t3_waddr", last_waddr, 64'h0012);
        check("t3_wdata", last_wdata, 64'h1234);
        check("t3_we_only_mem", we_bits(20), 64'd1 << 12);
        check("t3_mem_12", mem[8'h12], 64'h1234);

        // branches and jump: not-taken, taken forward, JMP, tight BEQ loop
        load_default();
        img[0] = 16'h7103;  img[1] = 16'hB115;  img[2] = 16'hA105;  img[3] = 16'hB102;
        img[6] = 16'hC003;  img[10] = 16'hA11F;
        exp_q = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd6, 16'd10, 16'd10, 16'd10};
        start_prog(0, 0);
        run_cycles(40);
        check("t4_fetch_count_ge8", {63'b0, rd_q.size() >= 8}, 64'd1);
        for (int i = 0; i < 8 && i < rd_q.size(); i++)
            check($sformatf("t4_fetch_%0d", i), rd_q[i], exp_q[i]);
        check("t4_not_halted", {63'b0, halt_log[40]}, 64'd0);

        // HALT at address 3
        load_default();
        img[0] = 16'hD000;  img[1] = 16'hD000;  img[2] = 16'hD000;  img[3] = 16'hE000;
        start_prog(0, 0);
        run_cycles(40);
        check("t5_halt_cycle", first_halt(), 64'd13);
        check("t5_req_quiet", count_req(13, 40), 64'd0);
        check("t5_pc", pc_out, 64'd4);
        check("t5_halted_hold", {63'b0, halted}, 64'd1);

        // illegal opcode behaves as HALT
        load_default();
        img[0] = 16'hF123;
        start_prog(0, 0);
        run_cycles(10);
        check("t5_illegal_halt", first_halt(), 64'd4);
        check("t5_illegal_retire", ret_bits(4), 64'b0100);

        // reset asserted during a stalled fetch
        load_default();
        start_prog(5, 0);
        run_cycles(2);
        check("t5_req_before_rst", {63'b0, mem_req}, 64'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_req_drop", {63'b0, mem_req}, 64'd0);
        check("t5_rst_addr", mem_addr, 64'd0);
        check("t5_rst_pc", pc_out, 64'd0);
        repeat (3) @(posedge clk);
        check("t5_rst_no_write", wr_count, 64'd0);

        // DW=32 core: PC wrap from max address, ADD wrap to zero
        img32[8'hFF] = 32'h0000_D000;
        img32[0] = 32'h0000_71FF;  img32[1] = 32'h0000_7201;  img32[2] = 32'h0000_0312;
        img32[3] = 32'h0000_7620;  img32[4] = 32'h0000_9360;  img32[5] = 32'h0000_9161;
        img32[6] = 32'h0000_E000;
        img32[8'h20] = 32'h0000_DEAD;
        img32[8'h21] = 32'h0000_0000;
        @(posedge clk);
        @(posedge clk);
        #1 rst32 = 1'b0;
        repeat (60) @(negedge clk);
        check("t6_fetch_ge2", {63'b0, rd32_q.size() >= 2}, 64'd1);
        if (rd32_q.size() >= 2) begin
            check("t6_fetch0", rd32_q[0], 64'hFFFF_FFFF);
            check("t6_fetch1", rd32_q[1], 64'd0);
        end
        check("t6_add_wrap", mem32[8'h20], 64'd0);
        check("t6_li_neg1", mem32[8'h21], 64'hFFFF_FFFF);
        check("t6_halted", {63'b0, halted32}, 64'd1);
        check("t6_pc", pc_out32, 64'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
